// File: rtl/sr_window_streamer.sv
// sr_window_streamer: raster pixel stream to border-padded 3x3 windows over two line buffers
module sr_window_streamer #(
   parameter int WIDTH       = 320,
   parameter int HEIGHT      = 240,
   parameter int PIXEL_WIDTH = 24,
   parameter int PAD_MODE    = 0
) (
   input  logic                         clk_w,
   input  logic                         rst_n,
   input  logic                         bypass,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [PIXEL_WIDTH-1:0]       s_data,
   input  logic                         s_sof,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [9*PIXEL_WIDTH-1:0]     m_window,
   output logic [$clog2(WIDTH)-1:0]     m_x,
   output logic [$clog2(HEIGHT)-1:0]    m_y,
   output logic                         m_sof,
   output logic                         m_eof,
   output logic                         frame_done,
   output logic [7:0]                   sync_err_cnt
);
   localparam int XW  = $clog2(WIDTH);
   localparam int YW  = $clog2(HEIGHT);
   localparam int YIW = $clog2(HEIGHT + 2);
   localparam int PW  = PIXEL_WIDTH;
   localparam logic [XW-1:0]  X_LAST  = XW'(WIDTH - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(HEIGHT - 1);
   localparam logic [YIW-1:0] IY_LAST = YIW'(HEIGHT - 1);
   localparam logic [YIW-1:0] IY_END  = YIW'(HEIGHT + 1);

   typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_EOF, BYPASS} state_t;

   state_t           state, state_nxt;
   logic             armed, slot_free, live_st, acc, start, resync, bm;
   logic             flush_adv, adv, load, last_pix, last_flush, rp, cp;
   logic [XW-1:0]    in_x, px, cx, ocx;
   logic [YIW-1:0]   in_y, py;
   logic [YW-1:0]    cy, ocy;
   logic [PW-1:0]    din;
   logic [PW-1:0]    lb0 [WIDTH];
   logic [PW-1:0]    lb1 [WIDTH];
   logic [PW-1:0]    sh  [3][3];
   logic [PW-1:0]    nsh [3][3];
   logic [9*PW-1:0]  win;

   always_comb begin
      slot_free  = !m_valid || m_ready;
      live_st    = state == STREAM || state == BYPASS;
      s_ready    = armed && (state == IDLE || (live_st && slot_free));
      acc        = s_valid && s_ready;
      start      = acc && s_sof && (state == IDLE || (live_st && (in_x != '0 || in_y != '0)));
      resync     = start && state != IDLE;
      bm         = state == IDLE ? bypass : state == BYPASS;
      flush_adv  = state == FLUSH && slot_free;
      adv        = (acc && (start || live_st)) || flush_adv;
      px         = start ? '0 : in_x;
      py         = start ? '0 : in_y;
      ocx        = start ? '0 : cx;
      ocy        = start ? '0 : cy;
      din        = flush_adv ? '0 : s_data;
      // a window exists once the pixel below-right of its centre has arrived
      load       = adv && (bm || py > YIW'(1) || (py == YIW'(1) && px != '0));
      last_pix   = acc && live_st && px == X_LAST && py == IY_LAST;
      last_flush = flush_adv && in_y == IY_END;
      state_nxt  = state;
      case (state)
         IDLE:     if (start) state_nxt = bypass ? BYPASS : STREAM;
         STREAM:   if (last_pix) state_nxt = FLUSH;
         BYPASS:   if (last_pix) state_nxt = WAIT_EOF;
         FLUSH:    if (last_flush) state_nxt = WAIT_EOF;
         WAIT_EOF: if (frame_done) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nsh[r][0] = sh[r][1];
         nsh[r][1] = sh[r][2];
      end
      nsh[0][2] = lb0[px];
      nsh[1][2] = lb1[px];
      nsh[2][2] = din;
   end

   // out-of-frame taps are zeroed or clamped onto the centre row/column
   always_comb begin
      win = '0;
      rp  = 1'b0;
      cp  = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            rp = (r == 0 && ocy == '0) || (r == 2 && ocy == Y_LAST);
            cp = (c == 0 && ocx == '0) || (c == 2 && ocx == X_LAST);
            win[(r*3+c)*PW +: PW] = bm ? ((r == 1 && c == 1) ? din : '0) :
                                    (PAD_MODE == 0 && (rp || cp)) ? '0 :
                                    nsh[rp ? 1 : r][cp ? 1 : c];
         end
   end

   always_ff @(posedge clk_w or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge clk_w)
      if (adv) begin
         lb0[px] <= lb1[px];
         lb1[px] <= din;
         sh      <= nsh;
      end

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         armed        <= 1'b0;
         in_x         <= '0;
         in_y         <= '0;
         cx           <= '0;
         cy           <= '0;
         m_valid      <= 1'b0;
         m_window     <= '0;
         m_x          <= '0;
         m_y          <= '0;
         m_sof        <= 1'b0;
         m_eof        <= 1'b0;
         frame_done   <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         armed <= 1'b1;
         if (adv) begin
            in_x <= px == X_LAST ? '0 : px + 1'b1;
            in_y <= px == X_LAST ? py + 1'b1 : py;
         end
         if (load) begin
            cx       <= ocx == X_LAST ? '0 : ocx + 1'b1;
            cy       <= ocx == X_LAST ? ocy + 1'b1 : ocy;
            m_window <= win;
            m_x      <= ocx;
            m_y      <= ocy;
            m_sof    <= ocx == '0 && ocy == '0;
            m_eof    <= ocx == X_LAST && ocy == Y_LAST;
         end else if (start) begin
            cx <= '0;
            cy <= '0;
         end
         m_valid    <= load || (m_valid && !m_ready && !resync);
         frame_done <= state == WAIT_EOF && !frame_done && m_valid && m_ready && m_eof;
         if (resync && sync_err_cnt != 8'hff) sync_err_cnt <= sync_err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_sr_window_streamer.sv
// tb_sr_window_streamer: scoreboard bench running zero-pad and replicate-pad instances side by side
module tb_sr_window_streamer;
   localparam int W = 4, H = 3, PW = 16, N = W * H;
   typedef logic [9*PW-1:0] val_t;
   typedef struct {
      val_t w0, w1;
      int   x, y;
      bit   sof, eof;
   } exp_t;

   logic          clk_w = 1'b0, rst_n = 1'b0, bypass = 1'b0;
   logic          s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
   logic [PW-1:0] s_data = '0;
   logic          s_ready, m_valid, m_sof, m_eof, frame_done;
   logic [1:0]    m_x, m_y;
   logic [7:0]    sync_err_cnt;
   val_t          m_window;
   logic          s_ready1, m_valid1, m_sof1, m_eof1, frame_done1;
   logic [1:0]    m_x1, m_y1;
   logic [7:0]    sync_err_cnt1;
   val_t          m_window1;

   exp_t q[$];
   int   fr[N];
   int   checks = 0, errors = 0;
   bit   rnd_ready = 1'b0, fd_exp = 1'b0;

   always #5 clk_w = ~clk_w;

   sr_window_streamer #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .PAD_MODE(0)) u_pad0 (
      .clk_w(clk_w), .rst_n(rst_n), .bypass(bypass), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window),
      .m_x(m_x), .m_y(m_y), .m_sof(m_sof), .m_eof(m_eof), .frame_done(frame_done),
      .sync_err_cnt(sync_err_cnt));

   sr_window_streamer #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .PAD_MODE(1)) u_pad1 (
      .clk_w(clk_w), .rst_n(rst_n), .bypass(bypass), .s_valid(s_valid), .s_ready(s_ready1),
      .s_data(s_data), .s_sof(s_sof), .m_valid(m_valid1), .m_ready(m_ready), .m_window(m_window1),
      .m_x(m_x1), .m_y(m_y1), .m_sof(m_sof1), .m_eof(m_eof1), .frame_done(frame_done1),
      .sync_err_cnt(sync_err_cnt1));

   task automatic chk(input string tag, input val_t got, input val_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic val_t exp_win(int cx, int cy, int mode, bit byp);
      val_t w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            int yy, xx;
            bit pad;
            yy  = cy + r - 1;
            xx  = cx + c - 1;
            pad = yy < 0 || yy >= H || xx < 0 || xx >= W;
            yy  = yy < 0 ? 0 : (yy >= H ? H - 1 : yy);
            xx  = xx < 0 ? 0 : (xx >= W ? W - 1 : xx);
            if (byp) w[(r*3+c)*PW +: PW] = (r == 1 && c == 1) ? PW'(fr[cy*W+cx]) : '0;
            else if (!(pad && mode == 0)) w[(r*3+c)*PW +: PW] = PW'(fr[yy*W+xx]);
         end
      return w;
   endfunction

   function automatic void push_win(int c, bit byp);
      exp_t e;
      e.x   = c % W;
      e.y   = c / W;
      e.w0  = exp_win(e.x, e.y, 0, byp);
      e.w1  = exp_win(e.x, e.y, 1, byp);
      e.sof = c == 0;
      e.eof = c == N - 1;
      q.push_back(e);
   endfunction

   function automatic void push_for(int k, bit byp);
      if (byp) push_win(k, 1'b1);
      else begin
         if (k >= W + 1) push_win(k - W - 1, 1'b0);
         if (k == N - 1) for (int c = k - W; c < N; c++) push_win(c, 1'b0);
      end
   endfunction

   task automatic send_pix(input int k, input bit sof, input bit byp, input bit gaps);
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk_w); #1; end
      s_valid = 1'b1;
      s_data  = PW'(fr[k]);
      s_sof   = sof;
      do begin @(negedge clk_w); #1; n++; end while (!s_ready && n < 100);
      chk("accept", val_t'(s_ready), val_t'(1'b1));
      if (sof) q.delete();
      push_for(k, byp);
      @(posedge clk_w); #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (byp) chk("byp_latency", val_t'(m_valid), val_t'(1'b1));
   endtask

   task automatic send_frame(input int base, input int n, input bit byp, input bit gaps);
      for (int i = 0; i < N; i++) fr[i] = base + i + 1;
      for (int k = 0; k < n; k++) send_pix(k, k == 0, byp, gaps);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin @(posedge clk_w); n++; end
      repeat (3) @(posedge clk_w);
      #1;
      chk("drain", val_t'(q.size()), val_t'(0));
   endtask

   task automatic rst_chk();
      chk("rst_s_ready", val_t'(s_ready), val_t'(1'b0));
      chk("rst_m_valid", val_t'(m_valid), val_t'(1'b0));
      chk("rst_window", m_window, val_t'(0));
      chk("rst_xy", val_t'({m_x, m_y}), val_t'(0));
      chk("rst_sof_eof", val_t'({m_sof, m_eof}), val_t'(0));
      chk("rst_frame_done", val_t'(frame_done), val_t'(1'b0));
      chk("rst_sync_err", val_t'(sync_err_cnt), val_t'(0));
   endtask

   always @(posedge clk_w) begin
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk_w) if (rst_n) begin
      chk("frame_done", val_t'(frame_done), val_t'(fd_exp));
      fd_exp = 1'b0;
      if (m_valid) begin
         if (q.size() == 0) chk("unexpected_win", val_t'(m_valid), val_t'(1'b0));
         else begin
            chk("win_pad0", m_window, q[0].w0);
            chk("win_pad1", m_window1, q[0].w1);
            chk("valid_pad1", val_t'(m_valid1), val_t'(1'b1));
            chk("m_x", val_t'(m_x), val_t'(q[0].x));
            chk("m_y", val_t'(m_y), val_t'(q[0].y));
            chk("m_sof", val_t'(m_sof), val_t'(q[0].sof));
            chk("m_eof", val_t'(m_eof), val_t'(q[0].eof));
            if (m_ready) begin
               fd_exp = q[0].eof;
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #12;
      rst_chk();
      @(posedge clk_w); #1;
      rst_n = 1'b1;
      @(posedge clk_w); #1;
      send_frame(0, N, 1'b0, 1'b0);
      chk("flush_s_ready", val_t'(s_ready), val_t'(1'b0));
      drain();
      chk("sync_err_clean", val_t'(sync_err_cnt), val_t'(0));
      rnd_ready = 1'b1;
      send_frame(20, N, 1'b0, 1'b1);
      drain();
      rnd_ready = 1'b0;
      bypass = 1'b1;
      send_frame(40, N, 1'b1, 1'b0);
      bypass = 1'b0;
      drain();
      send_frame(60, 6, 1'b0, 1'b0);
      send_frame(100, N, 1'b0, 1'b0);
      drain();
      chk("sync_err_resync", val_t'(sync_err_cnt), val_t'(1));
      rnd_ready = 1'b1;
      send_frame(140, N, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      rst_chk();
      q.delete();
      fd_exp = 1'b0;
      rnd_ready = 1'b0;
      repeat (2) @(posedge clk_w);
      #1;
      rst_n = 1'b1;
      @(posedge clk_w); #1;
      send_frame(180, N, 1'b0, 1'b0);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
